// File: rtl/persiana_pkg.sv
// Shared types for the blind actuator: controller states, level codes and
// the level-to-step decode.
package persiana_pkg;

  typedef enum logic [2:0] {
    HOMING,
    IDLE,
    UP,
    DOWN,
    DEAD,
    FAULT
  } estado_t;

  localparam logic [1:0] NIVEL_CERRADO = 2'b00;
  localparam logic [1:0] NIVEL_MEDIO   = 2'b01;
  localparam logic [1:0] NIVEL_ABIERTO = 2'b10;

  function automatic logic [31:0] nivel_a_pasos(input logic [1:0]  nivel,
                                                input logic [31:0] pasos_full);
    case (nivel)
      NIVEL_CERRADO: return '0;
      NIVEL_MEDIO:   return pasos_full >> 1;
      NIVEL_ABIERTO: return pasos_full;
      default:       return '0;
    endcase
  endfunction

endpackage

// File: rtl/persiana_prescaler.sv
// Modulo-STEP_DIV cycle counter; o_step strobes on the cycle the count wraps.
module persiana_prescaler #(
  parameter int unsigned STEP_DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_step
);

  localparam int unsigned   CW   = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);

  logic [CW-1:0] r_cnt;

  assign o_step = i_en && (r_cnt == LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr || o_step) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/persiana_motor.sv
// Stepped blind motor driver: homes on the bottom limit switch, tracks step
// position toward the decoded level, inserts dead time on reversals.
module persiana_motor
  import persiana_pkg::*;
#(
  parameter int unsigned STEPS_FULL  = 200,
  parameter int unsigned STEP_DIV    = 4,
  parameter int unsigned DEAD_TIME   = 3,
  parameter int unsigned POS_W       = 8,
  parameter int unsigned HOME_MARGIN = 8
) (
  input  logic             reloj,
  input  logic             reset_n,
  input  logic [1:0]       P,
  input  logic             limit_low,
  output logic             motor_up,
  output logic             motor_down,
  output logic [POS_W-1:0] pos,
  output logic             moving,
  output logic             at_target,
  output logic             fault
);

  localparam int unsigned HOME_LIMIT = STEPS_FULL + HOME_MARGIN;
  localparam int unsigned HW = $clog2(HOME_LIMIT + 1);
  localparam int unsigned DW = (DEAD_TIME > 1) ? $clog2(DEAD_TIME) : 1;

  estado_t          r_state, w_next;
  logic [POS_W-1:0] r_pos, w_pos_next;
  logic [POS_W-1:0] r_target, w_target;
  logic [HW-1:0]    r_home_cnt, w_home_next;
  logic [DW-1:0]    r_dead_cnt, w_dead_next;
  logic             r_motor_up, r_motor_down, r_moving, r_at_target, r_fault;
  logic             w_step, w_en, w_clr;

  // Code 11 keeps whatever level was last decoded.
  assign w_target = (P == 2'b11) ? r_target : POS_W'(nivel_a_pasos(P, STEPS_FULL));

  assign w_en  = (r_state == HOMING) || (r_state == UP) || (r_state == DOWN);
  assign w_clr = !w_en || (w_next != r_state);

  persiana_prescaler #(
    .STEP_DIV(STEP_DIV)
  ) u_prescaler (
    .i_clk  (reloj),
    .i_rst_n(reset_n),
    .i_en   (w_en),
    .i_clr  (w_clr),
    .o_step (w_step)
  );

  always_comb begin
    w_next      = r_state;
    w_pos_next  = r_pos;
    w_home_next = '0;
    w_dead_next = '0;
    case (r_state)
      HOMING: begin
        if (limit_low) begin
          w_pos_next = '0;
          w_next     = IDLE;
        end else begin
          w_home_next = r_home_cnt;
          if (w_step) begin
            w_home_next = r_home_cnt + 1'b1;
            if (r_home_cnt == HW'(HOME_LIMIT - 1)) w_next = FAULT;
          end
        end
      end
      IDLE: begin
        if (w_target > r_pos)      w_next = UP;
        else if (w_target < r_pos) w_next = DOWN;
      end
      UP: begin
        if (w_target > r_pos) begin
          if (w_step) begin
            w_pos_next = r_pos + 1'b1;
            if (w_pos_next == w_target) w_next = IDLE;
          end
        end else begin
          w_next = DEAD;
        end
      end
      DOWN: begin
        // The limit switch overrides the tracked count: position resyncs to 0.
        if (limit_low) begin
          w_pos_next = '0;
          w_next     = (w_target == '0) ? IDLE : DEAD;
        end else if (w_target < r_pos) begin
          if (w_step) begin
            w_pos_next = (r_pos == '0) ? '0 : r_pos - 1'b1;
            if (w_pos_next == w_target) w_next = IDLE;
          end
        end else begin
          w_next = DEAD;
        end
      end
      DEAD: begin
        if (r_dead_cnt == DW'(DEAD_TIME - 1)) begin
          if (w_target > r_pos)      w_next = UP;
          else if (w_target < r_pos) w_next = DOWN;
          else                       w_next = IDLE;
        end else begin
          w_dead_next = r_dead_cnt + 1'b1;
        end
      end
      FAULT:   w_next = FAULT;
      default: w_next = HOMING;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge reloj or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= HOMING;
      r_pos        <= '0;
      r_target     <= '0;
      r_home_cnt   <= '0;
      r_dead_cnt   <= '0;
      r_motor_up   <= 1'b0;
      r_motor_down <= 1'b0;
      r_moving     <= 1'b0;
      r_at_target  <= 1'b0;
      r_fault      <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_pos        <= w_pos_next;
      r_target     <= w_target;
      r_home_cnt   <= w_home_next;
      r_dead_cnt   <= w_dead_next;
      r_motor_up   <= (w_next == UP);
      r_motor_down <= (w_next == HOMING) || (w_next == DOWN);
      r_moving     <= (w_next == HOMING) || (w_next == UP) || (w_next == DOWN);
      r_at_target  <= (w_next == IDLE) && (w_pos_next == w_target);
      r_fault      <= (w_next == FAULT);
    end
  end

  assign motor_up   = r_motor_up;
  assign motor_down = r_motor_down;
  assign pos        = r_pos;
  assign moving     = r_moving;
  assign at_target  = r_at_target;
  assign fault      = r_fault;

endmodule

// File: tb/tb_persiana_motor.sv
// Directed bench for persiana_motor with STEPS_FULL=20, STEP_DIV=2, DEAD_TIME=3.
module tb_persiana_motor;

  logic       reloj = 1'b0;
  logic       reset_n;
  logic [1:0] P;
  logic       limit_low;
  logic       motor_up, motor_down, moving, at_target, fault;
  logic [7:0] pos;

  int unsigned total = 0;
  int unsigned bad   = 0;

  typedef struct {
    logic [1:0]  p;
    logic        lim;
    int unsigned n;
    logic        up;
    logic        dn;
    logic [7:0]  ps;
    logic        mv;
    logic        at;
  } vec_t;

  vec_t tbl[$];

  persiana_motor #(
    .STEPS_FULL (20),
    .STEP_DIV   (2),
    .DEAD_TIME  (3),
    .POS_W      (8),
    .HOME_MARGIN(8)
  ) dut (
    .reloj     (reloj),
    .reset_n   (reset_n),
    .P         (P),
    .limit_low (limit_low),
    .motor_up  (motor_up),
    .motor_down(motor_down),
    .pos       (pos),
    .moving    (moving),
    .at_target (at_target),
    .fault     (fault)
  );

  always #5 reloj = ~reloj;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge reloj);
    #1;
  endtask

  function automatic vec_t mk(logic [1:0] p, logic lim, int unsigned n, logic up,
                              logic dn, logic [7:0] ps, logic mv, logic at);
    vec_t v;
    v.p = p; v.lim = lim; v.n = n; v.up = up; v.dn = dn; v.ps = ps; v.mv = mv; v.at = at;
    return v;
  endfunction

  initial begin
    //                p      lim  n   up dn pos mv at
    tbl.push_back(mk(2'b10, 0,  1, 1, 0,  0, 1, 0)); // full open
    tbl.push_back(mk(2'b10, 0, 39, 1, 0, 19, 1, 0));
    tbl.push_back(mk(2'b10, 0,  1, 0, 0, 20, 0, 1));
    tbl.push_back(mk(2'b10, 0,  3, 0, 0, 20, 0, 1));
    tbl.push_back(mk(2'b00, 0,  1, 0, 1, 20, 1, 0)); // close, no dead time from IDLE
    tbl.push_back(mk(2'b00, 0, 39, 0, 1,  1, 1, 0));
    tbl.push_back(mk(2'b00, 0,  1, 0, 0,  0, 0, 1));
    tbl.push_back(mk(2'b10, 0,  1, 1, 0,  0, 1, 0)); // reversal at 12
    tbl.push_back(mk(2'b10, 0, 24, 1, 0, 12, 1, 0));
    tbl.push_back(mk(2'b00, 0,  1, 0, 0, 12, 0, 0));
    tbl.push_back(mk(2'b00, 0,  2, 0, 0, 12, 0, 0));
    tbl.push_back(mk(2'b00, 0,  1, 0, 1, 12, 1, 0));
    tbl.push_back(mk(2'b00, 0, 24, 0, 0,  0, 0, 1));
    tbl.push_back(mk(2'b01, 0,  1, 1, 0,  0, 1, 0)); // middle, then hold
    tbl.push_back(mk(2'b01, 0, 20, 0, 0, 10, 0, 1));
    tbl.push_back(mk(2'b11, 0,  5, 0, 0, 10, 0, 1));
    tbl.push_back(mk(2'b00, 0,  1, 0, 1, 10, 1, 0)); // resync on limit
    tbl.push_back(mk(2'b00, 0,  8, 0, 1,  6, 1, 0));
    tbl.push_back(mk(2'b00, 1,  1, 0, 0,  0, 0, 1));
    tbl.push_back(mk(2'b00, 0,  1, 0, 0,  0, 0, 1));
    tbl.push_back(mk(2'b00, 1,  2, 0, 0,  0, 0, 1)); // limit ignored in IDLE/UP
    tbl.push_back(mk(2'b01, 1,  1, 1, 0,  0, 1, 0));
    tbl.push_back(mk(2'b01, 1,  4, 1, 0,  2, 1, 0));
    tbl.push_back(mk(2'b01, 0, 16, 0, 0, 10, 0, 1));
    tbl.push_back(mk(2'b10, 0,  1, 1, 0, 10, 1, 0)); // same-direction change
    tbl.push_back(mk(2'b10, 0,  4, 1, 0, 12, 1, 0));
    tbl.push_back(mk(2'b11, 0,  2, 1, 0, 13, 1, 0));
    tbl.push_back(mk(2'b11, 0, 14, 0, 0, 20, 0, 1));
    tbl.push_back(mk(2'b00, 0,  1, 0, 1, 20, 1, 0));
    tbl.push_back(mk(2'b00, 0, 40, 0, 0,  0, 0, 1));
    tbl.push_back(mk(2'b10, 0,  1, 1, 0,  0, 1, 0)); // target==pos on non-step cycle
    tbl.push_back(mk(2'b10, 0, 20, 1, 0, 10, 1, 0));
    tbl.push_back(mk(2'b01, 0,  1, 0, 0, 10, 0, 0));
    tbl.push_back(mk(2'b01, 0,  2, 0, 0, 10, 0, 0));
    tbl.push_back(mk(2'b01, 0,  1, 0, 0, 10, 0, 1));
    tbl.push_back(mk(2'b10, 0,  1, 1, 0, 10, 1, 0)); // limit in DOWN with target 10
    tbl.push_back(mk(2'b10, 0, 20, 0, 0, 20, 0, 1));
    tbl.push_back(mk(2'b01, 0,  1, 0, 1, 20, 1, 0));
    tbl.push_back(mk(2'b01, 0,  4, 0, 1, 18, 1, 0));
    tbl.push_back(mk(2'b01, 1,  1, 0, 0,  0, 0, 0));
    tbl.push_back(mk(2'b01, 0,  2, 0, 0,  0, 0, 0));
    tbl.push_back(mk(2'b01, 0,  1, 1, 0,  0, 1, 0));
    tbl.push_back(mk(2'b01, 0, 20, 0, 0, 10, 0, 1));

    reset_n = 1'b0; P = 2'b00; limit_low = 1'b0;
    #12;
    chk("rst.up",    motor_up,   0);
    chk("rst.dn",    motor_down, 0);
    chk("rst.pos",   pos,        0);
    chk("rst.mv",    moving,     0);
    chk("rst.at",    at_target,  0);
    chk("rst.fault", fault,      0);

    @(negedge reloj);
    reset_n = 1'b1;
    tick(1);
    chk("home.dn_first", motor_down, 1);
    chk("home.mv_first", moving,     1);
    chk("home.up_first", motor_up,   0);
    tick(9);
    chk("home.dn_10", motor_down, 1);
    limit_low = 1'b1;
    tick(1);
    limit_low = 1'b0;
    chk("home.dn_done", motor_down, 0);
    chk("home.pos",     pos,        0);
    chk("home.at",      at_target,  1);
    chk("home.mv_done", moving,     0);

    for (int i = 0; i < tbl.size(); i++) begin
      P = tbl[i].p;
      limit_low = tbl[i].lim;
      tick(tbl[i].n);
      chk($sformatf("v%0d.up", i),  motor_up,   tbl[i].up);
      chk($sformatf("v%0d.dn", i),  motor_down, tbl[i].dn);
      chk($sformatf("v%0d.pos", i), pos,        tbl[i].ps);
      chk($sformatf("v%0d.mv", i),  moving,     tbl[i].mv);
      chk($sformatf("v%0d.at", i),  at_target,  tbl[i].at);
      chk($sformatf("v%0d.flt", i), fault,      0);
      chk($sformatf("v%0d.excl", i), motor_up & motor_down, 0);
    end

    // Asynchronous reset in the middle of an upward move.
    limit_low = 1'b0;
    P = 2'b10;
    tick(3);
    chk("amid.up",  motor_up, 1);
    chk("amid.pos", pos,      11);
    #2 reset_n = 1'b0;
    #1;
    chk("arst.up",  motor_up, 0);
    chk("arst.pos", pos,      0);
    chk("arst.mv",  moving,   0);

    // Homing timeout: 28 steps of 2 cycles with the limit never seen.
    @(negedge reloj);
    reset_n = 1'b1;
    tick(55);
    chk("tmo.flt_55", fault,      0);
    chk("tmo.dn_55",  motor_down, 1);
    tick(1);
    chk("tmo.flt_56", fault,      1);
    chk("tmo.dn_56",  motor_down, 0);
    chk("tmo.up_56",  motor_up,   0);
    chk("tmo.mv_56",  moving,     0);
    P = 2'b00;
    tick(5);
    chk("tmo.flt_p0", fault,    1);
    chk("tmo.up_p0",  motor_up, 0);
    P = 2'b01; limit_low = 1'b1;
    tick(5);
    chk("tmo.flt_p1", fault,      1);
    chk("tmo.dn_p1",  motor_down, 0);
    chk("tmo.at_p1",  at_target,  0);
    #2 reset_n = 1'b0;
    #1;
    chk("tmo.clr", fault, 0);
    @(negedge reloj);
    reset_n = 1'b1;
    tick(1);
    chk("rehome.idle", at_target, 0);
    chk("rehome.pos",  pos,       0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
